// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window controller.
// FSM encoding, minimum lockable dimension and default counter widths.
package sobel_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int MIN_DIM   = 3;
  localparam int DEF_COL_W = 12;
  localparam int DEF_ROW_W = 12;
  localparam int DEF_LEN_W = 13;

endpackage

// File: rtl/sobel_line_period_chk.sv
// Line-period checker: counts clk cycles between hsync rises and flags any
// period that differs from LINE_LEN with a sticky, clearable error.
module sobel_line_period_chk
  import sobel_pkg::*;
#(
  parameter int LINE_LEN = 2100,
  parameter int LEN_W    = DEF_LEN_W
) (
  input  logic clk,
  input  logic rst,
  input  logic hs_rise,
  input  logic err_clr,
  output logic len_err
);

  logic             started;
  logic [LEN_W-1:0] period_cnt;
  logic             mismatch;

  // The first rise after reset only arms the counter.
  assign mismatch = hs_rise & started & (period_cnt != LEN_W'(LINE_LEN));

  // Period counter restarts at 1 on a rise so it holds the full period at the next rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started    <= 1'b0;
      period_cnt <= '0;
    end else if (hs_rise) begin
      started    <= 1'b1;
      period_cnt <= LEN_W'(1);
    end else if (started && !(&period_cnt)) begin
      period_cnt <= period_cnt + LEN_W'(1);
    end
  end

  // Sticky error flag; a new mismatch beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err <= 1'b0;
    end else if (mismatch) begin
      len_err <= 1'b1;
    end else if (err_clr) begin
      len_err <= 1'b0;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequencing/border controller for the 3x3 Sobel window: tracks position, locks
// frame size and flags border pixels. Optional SOBEL_WCTRL_LEN_CHECK_EN adds a line-period check.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int LINE_LEN = 2100,
  parameter int COL_W    = DEF_COL_W,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int LEN_W    = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_dl,
  input  logic             vsync_dl,
  input  logic             de_dl,
  input  logic             err_clr,
  output logic             win_valid,
  output logic             border_top,
  output logic             border_bottom,
  output logic             border_left,
  output logic             border_right,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx,
  output logic [COL_W-1:0] act_width,
  output logic [ROW_W-1:0] act_height,
  output logic             locked,
  output logic             len_err
);

  state_t           state_r, state_n;
  logic             vs_q, de_q;
  logic             vs_rise, de_fall;
  logic [COL_W-1:0] col_cnt, col_inc, meas_w, w_now, act_w_n;
  logic [ROW_W-1:0] row_cnt, row_inc, meas_h, h_now, act_h_n;
  logic             locked_n;
  logic             active;

  assign vs_rise = vsync_dl & ~vs_q;
  assign de_fall = de_q & ~de_dl;
  assign col_inc = (&col_cnt) ? col_cnt : col_cnt + COL_W'(1);
  assign row_inc = (&row_cnt) ? row_cnt : row_cnt + ROW_W'(1);

  // Measurements as they stand after this cycle, so a coincident de fall is counted.
  assign w_now = de_fall ? col_cnt : meas_w;
  assign h_now = de_fall ? row_inc : row_cnt;

  // Edge-detect registers and position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
      meas_w  <= '0;
      meas_h  <= '0;
    end else begin
      vs_q <= vsync_dl;
      de_q <= de_dl;
      if (de_fall) begin
        meas_w  <= col_cnt;
        col_cnt <= '0;
      end else if (de_dl) begin
        col_cnt <= col_inc;
      end
      if (vs_rise) begin
        meas_h  <= h_now;
        row_cnt <= '0;
      end else if (de_fall) begin
        row_cnt <= row_inc;
      end
    end
  end

  // FSM state and locked dimensions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= WAIT_VS;
      act_width  <= '0;
      act_height <= '0;
      locked     <= 1'b0;
    end else begin
      state_r    <= state_n;
      act_width  <= act_w_n;
      act_height <= act_h_n;
      locked     <= locked_n;
    end
  end

  // Next-state logic: learn dimensions at each vsync rise, lock once they are usable.
  always_comb begin
    state_n  = state_r;
    act_w_n  = act_width;
    act_h_n  = act_height;
    locked_n = locked;
    case (state_r)
      WAIT_VS: begin
        if (vs_rise) begin
          state_n = MEASURE;
        end else begin
          state_n = WAIT_VS;
        end
      end
      MEASURE: begin
        if (vs_rise) begin
          act_w_n = w_now;
          act_h_n = h_now;
          if ((w_now >= COL_W'(MIN_DIM)) && (h_now >= ROW_W'(MIN_DIM))) begin
            state_n  = RUN;
            locked_n = 1'b1;
          end else begin
            state_n  = MEASURE;
          end
        end else begin
          state_n = MEASURE;
        end
      end
      RUN: begin
        if (vs_rise && ((w_now != act_width) || (h_now != act_height))) begin
          act_w_n  = w_now;
          act_h_n  = h_now;
          state_n  = MEASURE;
          locked_n = 1'b0;
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n  = WAIT_VS;
        locked_n = 1'b0;
      end
    endcase
  end

  // Flags are combinational from registered state so they stay aligned with the centre tap.
  always_comb begin
    active        = de_dl & locked;
    col_idx       = de_dl ? col_cnt : '0;
    row_idx       = de_dl ? row_cnt : '0;
    border_top    = active & (row_cnt == '0);
    border_bottom = active & (row_cnt == act_height - ROW_W'(1));
    border_left   = active & (col_cnt == '0);
    border_right  = active & (col_cnt == act_width - COL_W'(1));
    win_valid     = active & ~(border_top | border_bottom | border_left | border_right);
  end

`ifdef SOBEL_WCTRL_LEN_CHECK_EN
  logic hs_q;

  // hsync edge-detect register for the period checker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b0;
    end else begin
      hs_q <= hsync_dl;
    end
  end

  sobel_line_period_chk #(
    .LINE_LEN (LINE_LEN),
    .LEN_W    (LEN_W)
  ) u_len_chk (
    .clk     (clk),
    .rst     (rst),
    .hs_rise (hsync_dl & ~hs_q),
    .err_clr (err_clr),
    .len_err (len_err)
  );
`else
  logic unused_len_chk;
  assign unused_len_chk = ^{hsync_dl, err_clr, LEN_W'(LINE_LEN)};
  assign len_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl: stimulus pushes expected pixel flags and
// status values into queues; a negedge monitor pops and compares them.
module tb_sobel_window_ctrl;

  localparam int LL = 16;
`ifdef SOBEL_WCTRL_LEN_CHECK_EN
  localparam int LEN_ON = 1;
`else
  localparam int LEN_ON = 0;
`endif

  localparam int ST_LOCK  = 0;
  localparam int ST_AW    = 1;
  localparam int ST_AH    = 2;
  localparam int ST_LERR  = 3;
  localparam int ST_WV    = 4;
  localparam int ST_BT    = 5;
  localparam int ST_COL   = 6;
  localparam int ST_ROW   = 7;
  localparam int ST_MARK  = 8;
  localparam int ST_WVCNT = 9;
  localparam int ST_QEMPT = 10;

  logic        clk = 1'b0;
  logic        rst, hsync_dl, vsync_dl, de_dl, err_clr;
  logic        win_valid, border_top, border_bottom, border_left, border_right;
  logic [11:0] col_idx, row_idx, act_width, act_height;
  logic        locked, len_err;

  typedef struct packed {
    logic        wv, t, b, l, r;
    logic [11:0] c, rw;
  } pix_t;

  typedef struct {
    int id;
    int exp;
  } st_t;

  pix_t pix_q[$];
  st_t  st_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wv_total = 0;
  int   wv_mark = 0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(
    .LINE_LEN (LL),
    .COL_W    (12),
    .ROW_W    (12),
    .LEN_W    (13)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hsync_dl      (hsync_dl),
    .vsync_dl      (vsync_dl),
    .de_dl         (de_dl),
    .err_clr       (err_clr),
    .win_valid     (win_valid),
    .border_top    (border_top),
    .border_bottom (border_bottom),
    .border_left   (border_left),
    .border_right  (border_right),
    .col_idx       (col_idx),
    .row_idx       (row_idx),
    .act_width     (act_width),
    .act_height    (act_height),
    .locked        (locked),
    .len_err       (len_err)
  );

  function automatic string st_name(int id);
    case (id)
      ST_LOCK:  return "locked";
      ST_AW:    return "act_width";
      ST_AH:    return "act_height";
      ST_LERR:  return "len_err";
      ST_WV:    return "win_valid";
      ST_BT:    return "border_top";
      ST_COL:   return "col_idx";
      ST_ROW:   return "row_idx";
      ST_WVCNT: return "win_valid_count";
      ST_QEMPT: return "pixel_queue_left";
      default:  return "unknown";
    endcase
  endfunction

  // Monitor: drain status expectations, then check the pixel presented this cycle.
  always @(negedge clk) begin
    st_t  s;
    pix_t e, g;
    int   act;
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      case (s.id)
        ST_LOCK:  act = int'(locked);
        ST_AW:    act = int'(act_width);
        ST_AH:    act = int'(act_height);
        ST_LERR:  act = int'(len_err);
        ST_WV:    act = int'(win_valid);
        ST_BT:    act = int'(border_top);
        ST_COL:   act = int'(col_idx);
        ST_ROW:   act = int'(row_idx);
        ST_WVCNT: act = wv_total - wv_mark;
        ST_QEMPT: act = pix_q.size();
        default:  act = 0;
      endcase
      if (s.id == ST_MARK) begin
        wv_mark = wv_total;
      end else begin
        checks++;
        if (act != s.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d at %0t", st_name(s.id), act, s.exp, $time);
        end
      end
    end
    if (de_dl && !rst) begin
      wv_total += int'(win_valid);
      g = {win_valid, border_top, border_bottom, border_left, border_right, col_idx, row_idx};
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_underflow: got pixel %h with no expectation queued", g);
      end else begin
        e = pix_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL pixel r%0d c%0d: got wv/t/b/l/r=%b%b%b%b%b expected %b%b%b%b%b (col %0d row %0d)",
                   e.rw, e.c, g.wv, g.t, g.b, g.l, g.r, e.wv, e.t, e.b, e.l, e.r, g.c, g.rw);
        end
      end
    end
  end

  task automatic st(input int id, input int exp);
    st_t s;
    s.id  = id;
    s.exp = exp;
    st_q.push_back(s);
  endtask

  // One clock of stimulus; a de cycle also queues its expected flags.
  task automatic cyc(input bit hs, input bit vs, input bit de, input bit clr,
                     input int r, input int c, input bit elk, input int ew, input int eh);
    pix_t e;
    if (de) begin
      e.t  = elk && (r == 0);
      e.b  = elk && (r == eh - 1);
      e.l  = elk && (c == 0);
      e.r  = elk && (c == ew - 1);
      e.wv = elk && !(e.t || e.b || e.l || e.r);
      e.c  = 12'(c);
      e.rw = 12'(r);
      pix_q.push_back(e);
    end
    hsync_dl = hs;
    vsync_dl = vs;
    de_dl    = de;
    err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int w, input int per, input int vs_from, input int clr_at,
                      input int r, input bit elk, input int ew, input int eh);
    for (int i = 0; i < per; i++) begin
      cyc(i == 0, i >= vs_from, (i >= 3) && (i < 3 + w), i == clr_at, r, i - 3, elk, ew, eh);
    end
  endtask

  task automatic frame(input int w, input int h, input bit lead, input bit tail,
                       input bit elk, input int ew, input int eh);
    if (lead) line(0, LL, 0, -1, 0, 1'b0, 0, 0);
    for (int r = 0; r < h; r++) begin
      line(w, LL, (tail && (r == h - 1)) ? 3 + w : 99, -1, r, elk, ew, eh);
    end
  endtask

  initial begin
    rst = 1'b1; hsync_dl = 1'b0; vsync_dl = 1'b0; de_dl = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    st(ST_LOCK, 0); st(ST_AW, 0); st(ST_AH, 0); st(ST_LERR, 0); st(ST_WV, 0); st(ST_COL, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 10x6 frames: lock at the second vsync rise, 32 interior pixels per frame.
    frame(10, 6, 1, 0, 0, 0, 0);
    st(ST_LOCK, 0);
    frame(10, 6, 1, 0, 1, 10, 6);
    st(ST_LOCK, 1); st(ST_AW, 10); st(ST_AH, 6);
    st(ST_MARK, 0);
    frame(10, 6, 1, 0, 1, 10, 6);
    st(ST_WVCNT, 32);

    // Line-period errors: sticky, clearable, set beats clear.
    line(0, 17, 99, -1, 0, 0, 0, 0);
    line(0, LL, 99, -1, 0, 0, 0, 0);
    line(0, LL, 99, -1, 0, 0, 0, 0);
    st(ST_LERR, LEN_ON);
    line(0, LL, 99, 5, 0, 0, 0, 0);
    st(ST_LERR, 0);
    line(0, 15, 99, -1, 0, 0, 0, 0);
    line(0, LL, 99, 0, 0, 0, 0, 0);
    st(ST_LERR, LEN_ON);

    // Width change to 8: unlock, then relock with right border at col 7.
    frame(8, 6, 1, 0, 1, 10, 6);
    st(ST_LOCK, 1);
    frame(8, 6, 1, 0, 0, 0, 0);
    st(ST_LOCK, 0); st(ST_AW, 8); st(ST_AH, 6);
    frame(8, 6, 1, 0, 1, 8, 6);
    st(ST_LOCK, 1); st(ST_AW, 8);

    // vsync rise coinciding with the last de fall still counts that row.
    frame(8, 6, 1, 1, 1, 8, 6);
    frame(8, 6, 0, 0, 1, 8, 6);
    st(ST_LOCK, 1); st(ST_AH, 6);

    // Too-narrow frames never lock.
    frame(2, 6, 1, 0, 1, 8, 6);
    frame(2, 6, 1, 0, 0, 0, 0);
    st(ST_LOCK, 0); st(ST_AW, 2);
    st(ST_MARK, 0);
    frame(2, 6, 1, 0, 0, 0, 0);
    st(ST_WVCNT, 0); st(ST_LOCK, 0);

    // Relock at 10x6, then reset mid-line on an extra row beyond the height.
    frame(10, 6, 1, 0, 0, 0, 0);
    frame(10, 6, 1, 0, 1, 10, 6);
    st(ST_LOCK, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) cyc(0, 0, 1, 0, 6, c, 1, 10, 6);
    de_dl = 1'b1;
    #2 rst = 1'b1;
    #1;
    st(ST_LOCK, 0); st(ST_AW, 0); st(ST_AH, 0); st(ST_WV, 0);
    st(ST_BT, 0); st(ST_COL, 0); st(ST_ROW, 0); st(ST_LERR, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    de_dl = 1'b0;
    rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame(10, 6, 1, 0, 0, 0, 0);
    st(ST_LOCK, 0);
    frame(10, 6, 1, 0, 1, 10, 6);
    st(ST_LOCK, 1); st(ST_AW, 10); st(ST_LERR, 0);

    st(ST_QEMPT, 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
